multicycle_ctrl: RTL
====================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 CNT_WIDTH, default 32, width of retired-instruction counter.
REQ-002 clk  input  1  rising-edge clock, sole clock.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 opcode  input  6  instruction bits [31:26] from instruction register.
REQ-005 zero  input  1  ALU zero flag.
REQ-006 mem_ready  input  1  memory access completes this cycle.
REQ-007 pc_en  output  1  PC register load enable (branch condition already folded in).
REQ-008 i_or_d  output  1  memory address select: 0 PC, 1 ALU-out.
REQ-009 mem_read  output  1  memory read strobe.
REQ-010 mem_write  output  1  memory write strobe.
REQ-011 ir_write  output  1  instruction register load enable.
REQ-012 reg_dst  output  1  write-register select: 0 rt, 1 rd.
REQ-013 mem_to_reg  output  1  write-data select: 0 ALU-out, 1 memory-data register.
REQ-014 reg_write  output  1  register file write enable.
REQ-015 alu_src_a  output  1  ALU A: 0 PC, 1 A-register.
REQ-016 alu_src_b  output  2  ALU B: 00 B-reg, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2.
REQ-017 alu_op  output  2  00 add, 01 sub, 10 funct-decoded.
REQ-018 pc_source  output  2  PC source: 00 ALU result, 01 ALU-out, 10 jump target.
REQ-019 state  output  4  current state code.
REQ-020 illegal_op  output  1  unsupported opcode flag.
REQ-021 instr_count  output  CNT_WIDTH  retired-instruction count.

Function
REQ-022 Moore FSM, state register updated on rising clk; all outputs combinational from state (plus mem_ready/zero where stated); every output not listed for a state SHALL be 0.
REQ-023 States/codes: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, R_EXE 6, R_WB 7, BRANCH 8, JUMP 9, ADDI_EXE 10, ADDI_WB 11; codes 12-15 SHALL go to FETCH next cycle, outputs 0.
REQ-024 FETCH: mem_read=1, alu_src_b=01, ir_write=pc_en=mem_ready; stay until mem_ready=1, then DECODE.
REQ-025 DECODE: alu_src_b=11; next by opcode: 000000 R_EXE, 100011/101011 MEM_ADDR, 000100 BRANCH, 000010 JUMP, 001000 ADDI_EXE, other FETCH with illegal_op=1 this cycle only.
REQ-026 MEM_ADDR: alu_src_a=1, alu_src_b=10; next MEM_RD if opcode=100011 else MEM_WR.
REQ-027 MEM_RD: mem_read=1, i_or_d=1; stay until mem_ready, then MEM_WB. MEM_WB: reg_write=1, mem_to_reg=1; next FETCH.
REQ-028 MEM_WR: mem_write=1, i_or_d=1; stay until mem_ready, then FETCH.
REQ-029 R_EXE: alu_src_a=1, alu_op=10; next R_WB. R_WB: reg_write=1, reg_dst=1; next FETCH.
REQ-030 BRANCH: alu_src_a=1, alu_op=01, pc_source=01, pc_en=zero; next FETCH.
REQ-031 JUMP: pc_source=10, pc_en=1; next FETCH. ADDI_EXE: alu_src_a=1, alu_src_b=10; next ADDI_WB. ADDI_WB: reg_write=1; next FETCH.
REQ-032 Latency (mem_ready held 1): lw 5, sw 4, R/addi 4, beq/j 3 cycles; each mem_ready-low cycle in FETCH/MEM_RD/MEM_WR adds one cycle.

Reset
REQ-033 rst high at rising clk SHALL load state=FETCH and instr_count=0, overriding any transition, including mid-instruction and mid-wait.
REQ-034 While rst is high all control outputs SHALL be 0 (pc_en, ir_write, mem_read, mem_write, reg_write forced low); state reads 0.

Configuration
REQ-035 Macro MC_RETIRE_CNT_EN defined: instr_count increments by 1 on the cycle leaving MEM_WB, MEM_WR (mem_ready=1), R_WB, BRANCH, JUMP, ADDI_WB; illegal opcodes not counted; wraps 2^CNT_WIDTH-1 -> 0.
REQ-036 Macro undefined: no counter flops; instr_count SHALL be constant 0.

Verification
REQ-037 rst=1 two cycles, release, mem_ready=1, opcode=100011 -> states 0,1,2,3,4,0; reg_write=1 only in state 4; instr_count=1.
REQ-038 opcode=101011, mem_ready=0 for 3 cycles in MEM_WR -> mem_write=1 held 4 cycles, exit to FETCH on mem_ready=1.
REQ-039 opcode=000100, zero=0 then zero=1 -> pc_en=0 then pc_en=1 in BRANCH, pc_source=01.
REQ-040 opcode=111111 -> illegal_op=1 for one DECODE cycle, next state FETCH, instr_count unchanged.
REQ-041 rst asserted in R_EXE -> next state FETCH, reg_write never asserted, instr_count=0.
REQ-042 MC_RETIRE_CNT_EN, CNT_WIDTH=4, 16 jumps -> instr_count wraps 15 -> 0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore control FSM for a multicycle MIPS-style datapath.
// Outputs are decoded from the current state. pc_en and ir_write in FETCH
// also depend on mem_ready, and pc_en in BRANCH depends on zero.
// Optional retired-instruction counter: define MC_RETIRE_CNT_EN to build it.
// Without that macro, instr_count is tied to zero and has no flops.
module multicycle_ctrl #(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [5:0]           opcode,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 pc_en,
    output logic                 i_or_d,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 ir_write,
    output logic                 reg_dst,
    output logic                 mem_to_reg,
    output logic                 reg_write,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           alu_op,
    output logic [1:0]           pc_source,
    output logic [3:0]           state,
    output logic                 illegal_op,
    output logic [CNT_WIDTH-1:0] instr_count
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXE    = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_ADDI_EXE = 4'd10,
        S_ADDI_WB  = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    state_t r_state;
    state_t w_next;

    // State register; reset wins over every transition, including waits.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and output decode; every output is forced low during reset.
    always_comb begin
        w_next     = S_FETCH;
        pc_en      = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        pc_source  = 2'b00;
        illegal_op = 1'b0;

        case (r_state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_en     = mem_ready;
                w_next    = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_RTYPE:      w_next = S_R_EXE;
                    OP_LW, OP_SW:  w_next = S_MEM_ADDR;
                    OP_BEQ:        w_next = S_BRANCH;
                    OP_J:          w_next = S_JUMP;
                    OP_ADDI:       w_next = S_ADDI_EXE;
                    default: begin
                        w_next     = S_FETCH;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                w_next    = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                w_next   = mem_ready ? S_MEM_WB : S_MEM_RD;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                w_next     = S_FETCH;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                w_next    = mem_ready ? S_FETCH : S_MEM_WR;
            end
            S_R_EXE: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                w_next    = S_R_WB;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                w_next    = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                pc_source = 2'b01;
                pc_en     = zero;
                w_next    = S_FETCH;
            end
            S_JUMP: begin
                pc_source = 2'b10;
                pc_en     = 1'b1;
                w_next    = S_FETCH;
            end
            S_ADDI_EXE: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                w_next    = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                reg_write = 1'b1;
                w_next    = S_FETCH;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase

        if (rst) begin
            pc_en      = 1'b0;
            i_or_d     = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            ir_write   = 1'b0;
            reg_dst    = 1'b0;
            mem_to_reg = 1'b0;
            reg_write  = 1'b0;
            alu_src_a  = 1'b0;
            alu_src_b  = 2'b00;
            alu_op     = 2'b00;
            pc_source  = 2'b00;
            illegal_op = 1'b0;
        end
    end

    assign state = rst ? 4'd0 : r_state;

`ifdef MC_RETIRE_CNT_EN
    logic                 w_retire;
    logic [CNT_WIDTH-1:0] r_instr_count;

    assign w_retire = (r_state == S_MEM_WB) ||
                      ((r_state == S_MEM_WR) && mem_ready) ||
                      (r_state == S_R_WB) ||
                      (r_state == S_BRANCH) ||
                      (r_state == S_JUMP) ||
                      (r_state == S_ADDI_WB);

    // Retired-instruction counter; wraps naturally at full scale.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr_count <= '0;
        end else if (w_retire) begin
            r_instr_count <= r_instr_count + 1'b1;
        end
    end

    assign instr_count = r_instr_count;
`else
    assign instr_count = '0;
`endif

endmodule
